// File: rtl/ipm2l_fifo_pkt_writer.sv
// Write-side frame producer for the ipm2l FIFO: admits a frame only when the whole
// frame fits, writes a length header then the payload, and pads/truncates bad lengths.
module ipm2l_fifo_pkt_writer #(
  parameter int DATA_WIDTH      = 64,
  parameter int WR_DEPTH_WIDTH  = 9,
  parameter int LEN_WIDTH       = 9,
  parameter int MAX_PKT_LEN     = 256,
  parameter int DROP_ON_NOSPACE = 0
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_last,
  input  logic [LEN_WIDTH-1:0]      s_len,
  output logic                      w_en,
  output logic [DATA_WIDTH-1:0]     w_data,
  input  logic                      wfull,
  input  logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               drop_cnt,
  output logic                      err_len
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_HDR    = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PAD    = 3'd5;
  localparam logic [2:0] ST_TRUNC  = 3'd6;
  localparam logic [2:0] ST_DROP   = 3'd7;

  localparam int                FREE_W   = WR_DEPTH_WIDTH + 2;
  localparam logic [FREE_W-1:0] CAPACITY = FREE_W'(1) << WR_DEPTH_WIDTH;
  localparam logic [1:0]        SETTLED  = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  bc_q, bc_d;
  logic [1:0]            settle_q, settle_d;
  logic                  w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  err_len_q, err_len_d;

  logic                  accept_s;
  logic                  len_bad_s;
  logic                  settled_s;
  logic [FREE_W-1:0]     free_s;
  logic [FREE_W-1:0]     need_s;
  logic [LEN_WIDTH:0]    bc_inc_s;
  logic [LEN_WIDTH:0]    len_ext_s;

  assign accept_s  = s_valid && s_ready;
  assign len_bad_s = (s_len == {LEN_WIDTH{1'b0}}) ||
                     ({1'b0, s_len} > (LEN_WIDTH+1)'(MAX_PKT_LEN));
  assign settled_s = (settle_q == SETTLED);
  assign free_s    = CAPACITY - FREE_W'(wr_water_level);
  assign need_s    = FREE_W'(len_q) + FREE_W'(1);
  assign bc_inc_s  = {1'b0, bc_q} + (LEN_WIDTH+1)'(1);
  assign len_ext_s = {1'b0, len_q};

  assign w_en     = w_en_q;
  assign w_data   = w_data_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign err_len  = err_len_q;

  // Upstream ready depends only on state and FIFO full, never on s_valid.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_DATA:  s_ready = !wfull;
      ST_TRUNC: s_ready = 1'b1;
      ST_DROP:  s_ready = 1'b1;
      default:  s_ready = 1'b0;
    endcase
  end

  // Frame FSM: admission, header/payload writes and length repair.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bc_d       = bc_q;
    w_en_d     = 1'b0;
    w_data_d   = w_data_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_len_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          len_d = s_len;
          if (len_bad_s)      state_d = ST_DROP;
          else if (settled_s) state_d = ST_CHECK;
          else                state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settled_s) state_d = ST_CHECK;
        else           state_d = ST_SETTLE;
      end
      ST_CHECK: begin
        if (free_s >= need_s)          state_d = ST_HDR;
        else if (DROP_ON_NOSPACE != 0) state_d = ST_DROP;
        else                           state_d = ST_CHECK;
      end
      ST_HDR: begin
        if (!wfull) begin
          w_en_d   = 1'b1;
          w_data_d = DATA_WIDTH'(len_q);
          bc_d     = {LEN_WIDTH{1'b0}};
          state_d  = ST_DATA;
        end else begin
          state_d  = ST_HDR;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          w_en_d   = 1'b1;
          w_data_d = s_data;
          bc_d     = bc_inc_s[LEN_WIDTH-1:0];
          if (bc_inc_s == len_ext_s) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (s_last) begin
              state_d = ST_IDLE;
            end else begin
              err_len_d = 1'b1;
              state_d   = ST_TRUNC;
            end
          end else if (s_last) begin
            err_len_d = 1'b1;
            state_d   = ST_PAD;
          end else begin
            state_d   = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAD: begin
        if (!wfull) begin
          w_en_d   = 1'b1;
          w_data_d = {DATA_WIDTH{1'b0}};
          bc_d     = bc_inc_s[LEN_WIDTH-1:0];
          if (bc_inc_s == len_ext_s) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_PAD;
          end
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_TRUNC: begin
        if (accept_s && s_last) state_d = ST_IDLE;
        else                    state_d = ST_TRUNC;
      end
      ST_DROP: begin
        if (accept_s && s_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cycles since the last write; the level input needs two to catch up.
  always_comb begin
    if (w_en_d)         settle_d = 2'd0;
    else if (settled_s) settle_d = SETTLED;
    else                settle_d = settle_q + 2'd1;
  end

  // State and output registers.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= ST_IDLE;
      len_q      <= {LEN_WIDTH{1'b0}};
      bc_q       <= {LEN_WIDTH{1'b0}};
      settle_q   <= SETTLED;
      w_en_q     <= 1'b0;
      w_data_q   <= {DATA_WIDTH{1'b0}};
      pkt_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bc_q       <= bc_d;
      settle_q   <= settle_d;
      w_en_q     <= w_en_d;
      w_data_q   <= w_data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

endmodule

// File: tb/tb_ipm2l_fifo_pkt_writer.sv
// Scoreboard bench: tests push expected FIFO words, a negedge monitor pops and compares.
// Instance 0 stalls on no space, instance 1 drops on no space.
module tb_ipm2l_fifo_pkt_writer;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;

  logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
  logic        s_ready0, s_ready1;
  logic [63:0] s_data0 = 64'd0, s_data1 = 64'd0;
  logic        s_last0 = 1'b0, s_last1 = 1'b0;
  logic [8:0]  s_len0 = 9'd0, s_len1 = 9'd0;
  logic        w_en0, w_en1;
  logic [63:0] w_data0, w_data1;
  logic        wfull0 = 1'b0, wfull1 = 1'b0;
  logic [9:0]  wl0 = 10'd0, wl1 = 10'd0;
  logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt0, drop_cnt1;
  logic        err_len0, err_len1;

  int n_checks = 0;
  int n_err    = 0;
  int err_cnt0 = 0;
  int err_cnt1 = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_w;

  always #5 wclk = ~wclk;

  ipm2l_fifo_pkt_writer #(.DROP_ON_NOSPACE(0)) dut0 (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_data(s_data0), .s_last(s_last0), .s_len(s_len0), .w_en(w_en0),
    .w_data(w_data0), .wfull(wfull0), .wr_water_level(wl0),
    .pkt_cnt(pkt_cnt0), .drop_cnt(drop_cnt0), .err_len(err_len0)
  );

  ipm2l_fifo_pkt_writer #(.DROP_ON_NOSPACE(1)) dut1 (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .s_last(s_last1), .s_len(s_len1), .w_en(w_en1),
    .w_data(w_data1), .wfull(wfull1), .wr_water_level(wl1),
    .pkt_cnt(pkt_cnt1), .drop_cnt(drop_cnt1), .err_len(err_len1)
  );

  // Monitor: every FIFO write must match the next expected word.
  always @(negedge wclk) begin
    if (w_en0) begin
      n_checks++;
      if (exp_q0.size() == 0) begin
        n_err++;
        $display("FAIL wr0_unexpected: got write %0h, required no write", w_data0);
      end else begin
        exp_w = exp_q0.pop_front();
        if (w_data0 !== exp_w) begin
          n_err++;
          $display("FAIL wr0_data: got %0h, required %0h", w_data0, exp_w);
        end
      end
    end
    if (w_en1) begin
      n_checks++;
      n_err++;
      $display("FAIL wr1_unexpected: got write %0h, required no write", w_data1);
    end
    if (err_len0) err_cnt0++;
    if (err_len1) err_cnt1++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Send nw words base+1..base+nw with length len; bounded wait per handshake.
  task automatic send_frame(input int sel, input logic [8:0] len, input int nw,
                            input logic [63:0] base);
    bit ok;
    for (int i = 0; i < nw; i++) begin
      if (sel == 0) begin
        s_valid0 = 1'b1; s_data0 = base + 64'(i + 1); s_last0 = (i == nw - 1); s_len0 = len;
      end else begin
        s_valid1 = 1'b1; s_data1 = base + 64'(i + 1); s_last1 = (i == nw - 1); s_len1 = len;
      end
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge wclk);
        if ((sel == 0) ? s_ready0 : s_ready1) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge wclk);
      #1;
      if (!ok) begin
        n_checks++;
        n_err++;
        $display("FAIL handshake_timeout: got no s_ready on word %0d, required accept", i);
        break;
      end
    end
    s_valid0 = 1'b0; s_last0 = 1'b0;
    s_valid1 = 1'b0; s_last1 = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge wclk);
  endtask

  initial begin
    bit done;
    repeat (3) @(negedge wclk);
    wrst = 1'b0;
    #1;
    chk("rst_w_en", 64'(w_en0), 64'd0);
    chk("rst_w_data", w_data0, 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt0), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt0), 64'd0);
    chk("rst_err_len", 64'(err_len0), 64'd0);
    chk("rst_s_ready", 64'(s_ready0), 64'd0);
    @(posedge wclk);
    #1;

    // 4-word frame into an empty FIFO
    exp_q0.push_back(64'd4);
    for (int i = 1; i <= 4; i++) exp_q0.push_back(64'(i));
    send_frame(0, 9'd4, 4, 64'd0);
    idle_cycles(8);
    chk("t1_drained", 64'(exp_q0.size()), 64'd0);
    chk("t1_pkt_cnt", 64'(pkt_cnt0), 64'd1);
    chk("t1_err_cnt", 64'(err_cnt0), 64'd0);

    // free=3 < 5: stall, then free=5 admits the frame
    wl0 = 10'd509;
    fork
      send_frame(0, 9'd4, 4, 64'h40);
      begin
        idle_cycles(20);
        chk("t2_stall_ready", 64'(s_ready0), 64'd0);
        exp_q0.push_back(64'd4);
        for (int i = 1; i <= 4; i++) exp_q0.push_back(64'h40 + 64'(i));
        wl0 = 10'd507;
      end
    join
    idle_cycles(8);
    chk("t2_drained", 64'(exp_q0.size()), 64'd0);
    chk("t2_pkt_cnt", 64'(pkt_cnt0), 64'd2);
    wl0 = 10'd0;

    // drop-on-nospace instance: frame consumed, nothing written
    wl1 = 10'd509;
    send_frame(1, 9'd4, 4, 64'h80);
    idle_cycles(8);
    chk("t3_drop_cnt", 64'(drop_cnt1), 64'd1);
    chk("t3_pkt_cnt", 64'(pkt_cnt1), 64'd0);

    // short frame padded with zeros
    exp_q0.push_back(64'd5);
    exp_q0.push_back(64'h11); exp_q0.push_back(64'h12); exp_q0.push_back(64'h13);
    exp_q0.push_back(64'd0);  exp_q0.push_back(64'd0);
    send_frame(0, 9'd5, 3, 64'h10);
    idle_cycles(8);
    chk("t4_drained", 64'(exp_q0.size()), 64'd0);
    chk("t4_err_cnt", 64'(err_cnt0), 64'd1);
    chk("t4_pkt_cnt", 64'(pkt_cnt0), 64'd3);

    // long frame truncated
    exp_q0.push_back(64'd2);
    exp_q0.push_back(64'h21); exp_q0.push_back(64'h22);
    send_frame(0, 9'd2, 4, 64'h20);
    idle_cycles(8);
    chk("t5_drained", 64'(exp_q0.size()), 64'd0);
    chk("t5_err_cnt", 64'(err_cnt0), 64'd2);
    chk("t5_pkt_cnt", 64'(pkt_cnt0), 64'd4);

    // illegal lengths dropped
    send_frame(0, 9'd0, 1, 64'h30);
    send_frame(0, 9'd257, 2, 64'h30);
    idle_cycles(8);
    chk("t6_drop_cnt", 64'(drop_cnt0), 64'd2);
    chk("t6_pkt_cnt", 64'(pkt_cnt0), 64'd4);
    chk("t6_err_cnt", 64'(err_cnt0), 64'd2);

    // reset in the middle of DATA
    @(posedge wclk);
    #1;
    exp_q0.push_back(64'd8);
    for (int i = 0; i < 3; i++) exp_q0.push_back(64'h55);
    s_valid0 = 1'b1; s_data0 = 64'h55; s_last0 = 1'b0; s_len0 = 9'd8;
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge wclk);
      #1;
      if (exp_q0.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("t7_reached_data", 64'(done), 64'd1);
    wrst = 1'b1;
    s_valid0 = 1'b0;
    #1;
    chk("t7_w_en", 64'(w_en0), 64'd0);
    chk("t7_w_data", w_data0, 64'd0);
    chk("t7_pkt_cnt", 64'(pkt_cnt0), 64'd0);
    chk("t7_drop_cnt", 64'(drop_cnt0), 64'd0);
    chk("t7_err_len", 64'(err_len0), 64'd0);
    chk("t7_s_ready", 64'(s_ready0), 64'd0);
    chk("t7_drop_cnt1", 64'(drop_cnt1), 64'd0);
    @(negedge wclk);
    wrst = 1'b0;
    idle_cycles(4);
    chk("t7_no_write_after", 64'(exp_q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ipm2l_fifo_pkt_writer.md
# ipm2l_fifo_pkt_writer

Write-side frame producer for the ipm2l FIFO controller. Accepts an upstream valid/ready word stream with a per-frame length, admits a frame only when the FIFO has room for the whole frame, and writes a length header word followed by the payload. Length violations are repaired by padding or truncating, so the read side always sees header-consistent frames. Sits in the wclk domain, between the DMA/stream source and the FIFO controller write port.

## Interface
- DATA_WIDTH, 64: stream and FIFO word width.
- WR_DEPTH_WIDTH, 9: FIFO address width; capacity is 2^WR_DEPTH_WIDTH words.
- LEN_WIDTH, 9: width of s_len.
- MAX_PKT_LEN, 256: largest legal payload length in words. Must satisfy MAX_PKT_LEN + 1 <= 2^WR_DEPTH_WIDTH.
- DROP_ON_NOSPACE, 0: 0 = stall until space is available; 1 = drop the frame.

- wclk  in  1  write clock.
- wrst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream word accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  payload word.
- s_last  in  1  last word of frame.
- s_len  in  LEN_WIDTH  payload length in words; valid with the first word of a frame.
- w_en  out  1  FIFO write enable; registered.
- w_data  out  DATA_WIDTH  FIFO write data; registered.
- wfull  in  1  FIFO full flag.
- wr_water_level  in  WR_DEPTH_WIDTH+1  FIFO write-side fill level.
- pkt_cnt  out  16  frames written; wraps.
- drop_cnt  out  16  frames dropped; wraps.
- err_len  out  1  one-cycle pulse on a length mismatch.

## Operation
- States:
  - IDLE
  - SETTLE: waits 2 cycles after the last w_en so wr_water_level reflects all issued writes.
  - CHECK
  - HDR
  - DATA
  - PAD
  - TRUNC
  - DROP
- IDLE: s_ready=0. On s_valid, latch s_len into len_r (first word not consumed). Then:
  - len_r==0 or len_r>MAX_PKT_LEN -> DROP.
  - otherwise -> SETTLE.
- CHECK: free = 2^WR_DEPTH_WIDTH - wr_water_level, computed at WR_DEPTH_WIDTH+2 bits. Then:
  - free >= len_r+1 -> HDR.
  - else, DROP_ON_NOSPACE=1 -> DROP.
  - else, stay in CHECK and re-evaluate every cycle.
- HDR: one cycle, s_ready=0. Write w_data = {zero-extended len_r}, w_en=1. -> DATA; beat counter bc=0.
- DATA: s_ready=1. Each accepted word is written and increments bc.
  - s_last && bc+1==len_r -> IDLE, pkt_cnt++.
  - s_last && bc+1<len_r -> err_len, then PAD.
  - !s_last && bc+1==len_r -> err_len, then TRUNC.
- PAD: s_ready=0. Write zero words until bc==len_r, then -> IDLE, pkt_cnt++.
- TRUNC: s_ready=1. Discard words through s_last, then -> IDLE. pkt_cnt has already been incremented at TRUNC entry.
- DROP: s_ready=1. Discard words through s_last, then -> IDLE, drop_cnt++ on exit.
- w_en is never asserted while wfull=1. If wfull is seen in HDR, DATA or PAD, the write is held and s_ready deasserts; this is a safety path that admission control makes unreachable.

## Timing
- Reset values:
  - state=IDLE, s_ready=0, w_en=0, w_data=0, pkt_cnt=0, drop_cnt=0, err_len=0.
  - The settle counter is preset to "settled".
- Write latency: an accepted word appears on w_en/w_data exactly 1 cycle later.
- s_ready is decoded from state and wfull only; there is no combinational path from s_valid.
- Minimum frame overhead: IDLE(1) + SETTLE(0-2) + CHECK(1) + HDR(1) cycles before the first payload word is accepted.
- wr_water_level lags by one cycle and over-reports while the read-pointer sync is pending. Admission is therefore conservative, which is the required behaviour.
- wrst mid-frame: everything returns to reset values immediately. The partial frame is abandoned, and resetting the FIFO controller together with this block is mandatory.

## Test plan
- Reset, then a 4-word frame (s_len=4, data 1..4) into an empty FIFO -> w_data sequence 0x4,1,2,3,4 on 5 consecutive w_en cycles; pkt_cnt=1; err_len never asserted.
- wr_water_level=509 with depth 512 (free=3), frame s_len=4, DROP_ON_NOSPACE=0 -> s_ready=0 held. Lower the level to 507 -> header plus 4 words written.
- Same fill with DROP_ON_NOSPACE=1 -> frame consumed with no w_en; drop_cnt=1.
- s_len=5 with s_last on word 3 -> err_len pulses once; FIFO receives 0x5,d1,d2,d3,0,0.
- s_len=2 with 4 words sent -> err_len pulses; FIFO receives 0x2,d1,d2; words 3-4 are accepted but not written; pkt_cnt increments.
- s_len=0 and s_len=MAX_PKT_LEN+1 -> both dropped; drop_cnt=2. Assert wrst during DATA -> all outputs return to reset values on the same edge.
